// File: rtl/pmem_gen.sv
// Program memory with a 1-cycle registered fetch port and a halfword-stream burst loader.
// Optional macro PMEM_GEN_RANGE_CHECK_EN enables out-of-range fetch faulting.
module pmem_gen #(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH_WORDS = 32768,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013,
  localparam int         ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       pc_read_c0,
  input  logic              stall_c0,
  output logic [DATA_W-1:0] instr_reg_c1,
  output logic              instr_valid_c1,
  input  logic              load_start_c0,
  input  logic [ADDR_W-1:0] load_base_c0,
  input  logic [ADDR_W:0]   load_count_c0,
  input  logic              load_valid_c0,
  input  logic [15:0]       load_half_c0,
  output logic              load_ready_c0,
  output logic              load_busy,
  output logic              load_done,
  output logic              fault_c1
);

  localparam int OFF_W  = (DATA_W == 64) ? 3 : 2;
  localparam int HI_LSB = ADDR_W + OFF_W;
  localparam int HALVES = DATA_W / 16;
  localparam int HIDX_W = $clog2(HALVES);

  localparam logic [DATA_W-1:0] NOP_W     = DATA_W'(NOP_INSTR);
  localparam logic [HIDX_W-1:0] HALF_LAST = HIDX_W'(HALVES - 1);
  localparam logic [HIDX_W-1:0] HALF_ONE  = HIDX_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  state_t            state;
  logic [HIDX_W-1:0] half_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] word_buf;
  logic              xfer;
  logic              wr_en;
  logic [ADDR_W-1:0] fetch_idx;
  logic [31:0]       pc_hi;

  assign fetch_idx = pc_read_c0[HI_LSB-1:OFF_W];
  assign pc_hi     = pc_read_c0 >> HI_LSB;
  assign xfer      = load_valid_c0 && load_ready_c0;
  assign wr_en     = (state == WRITE);

  // Memory is never reset; a same-cycle fetch to the written index sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= word_buf;
  end

  // Loader FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      half_idx      <= '0;
      wr_addr       <= '0;
      remaining     <= '0;
      load_ready_c0 <= 1'b0;
      load_busy     <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start_c0 && (load_count_c0 != '0)) begin
            state         <= COLLECT;
            wr_addr       <= load_base_c0;
            remaining     <= load_count_c0;
            half_idx      <= '0;
            load_ready_c0 <= 1'b1;
            load_busy     <= 1'b1;
          end
        end
        COLLECT: begin
          if (xfer) begin
            word_buf[16*half_idx +: 16] <= load_half_c0;
            if (half_idx == HALF_LAST) begin
              half_idx      <= '0;
              state         <= WRITE;
              load_ready_c0 <= 1'b0;
            end else begin
              half_idx <= half_idx + HALF_ONE;
            end
          end
        end
        WRITE: begin
          wr_addr   <= wr_addr + ADDR_ONE;
          remaining <= remaining - CNT_ONE;
          if (remaining == CNT_ONE) begin
            state     <= IDLE;
            load_busy <= 1'b0;
            load_done <= 1'b1;
          end else begin
            state         <= COLLECT;
            load_ready_c0 <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          load_ready_c0 <= 1'b0;
          load_busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PMEM_GEN_RANGE_CHECK_EN
  logic range_bad;
  assign range_bad = (pc_hi != '0) || (pc_read_c0[OFF_W-1:0] != '0);

  // Fetch stage: out-of-range addresses return NOP and raise fault
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_reg_c1   <= NOP_W;
      instr_valid_c1 <= 1'b0;
      fault_c1       <= 1'b0;
    end else if (!stall_c0) begin
      instr_valid_c1 <= 1'b1;
      if (range_bad) begin
        instr_reg_c1 <= NOP_W;
        fault_c1     <= 1'b1;
      end else begin
        instr_reg_c1 <= mem[fetch_idx];
        fault_c1     <= 1'b0;
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = (^pc_hi) ^ (^pc_read_c0[OFF_W-1:0]);
  assign fault_c1  = 1'b0;

  // Fetch stage: address bits outside the index field alias
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_reg_c1   <= NOP_W;
      instr_valid_c1 <= 1'b0;
    end else if (!stall_c0) begin
      instr_reg_c1   <= mem[fetch_idx];
      instr_valid_c1 <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pmem_gen.sv
// Directed self-checking bench for pmem_gen (DATA_W=32, DEPTH_WORDS=16).
module tb_pmem_gen;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   pc_read_c0 = '0;
  logic          stall_c0 = 1'b0;
  logic [DW-1:0] instr_reg_c1;
  logic          instr_valid_c1;
  logic          load_start_c0 = 1'b0;
  logic [AW-1:0] load_base_c0 = '0;
  logic [AW:0]   load_count_c0 = '0;
  logic          load_valid_c0 = 1'b0;
  logic [15:0]   load_half_c0 = '0;
  logic          load_ready_c0;
  logic          load_busy;
  logic          load_done;
  logic          fault_c1;

  int checks = 0;
  int errors = 0;

  pmem_gen #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .pc_read_c0(pc_read_c0), .stall_c0(stall_c0),
    .instr_reg_c1(instr_reg_c1), .instr_valid_c1(instr_valid_c1),
    .load_start_c0(load_start_c0), .load_base_c0(load_base_c0),
    .load_count_c0(load_count_c0), .load_valid_c0(load_valid_c0),
    .load_half_c0(load_half_c0), .load_ready_c0(load_ready_c0),
    .load_busy(load_busy), .load_done(load_done), .fault_c1(fault_c1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input int base, input int cnt);
    load_start_c0 = 1'b1;
    load_base_c0  = AW'(base);
    load_count_c0 = (AW + 1)'(cnt);
    step();
    load_start_c0 = 1'b0;
    check("busy_after_start", load_busy, 1);
  endtask

  task automatic send_half(input logic [15:0] h);
    int n;
    n = 0;
    load_valid_c0 = 1'b1;
    load_half_c0  = h;
    while (!load_ready_c0 && n < 8) begin
      step();
      n++;
    end
    check("ready_wait", load_ready_c0, 1);
    step();
    load_valid_c0 = 1'b0;
  endtask

  task automatic finish_burst();
    int n;
    n = 0;
    while (!load_done && n < 8) begin
      step();
      n++;
    end
    check("load_done", load_done, 1);
    check("busy_fall", load_busy, 0);
    step();
    check("done_one_cycle", load_done, 0);
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    pc_read_c0 = pc;
    step();
    check(tag, instr_reg_c1, exp);
    check("valid", instr_valid_c1, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    step();
    step();
    check("rst_instr", instr_reg_c1, NOP);
    check("rst_valid", instr_valid_c1, 0);
    check("rst_fault", fault_c1, 0);
    check("rst_ready", load_ready_c0, 0);
    check("rst_busy", load_busy, 0);
    check("rst_done", load_done, 0);
    reset_n = 1'b1;

    start_burst(0, 1);
    send_half(16'hBEEF);
    send_half(16'hDEAD);
    finish_burst();
    fetch("fetch_w0", 32'h0, 32'hDEADBEEF);

    start_burst(5, 2);
    send_half(16'h1111);
    send_half(16'h2222);
    send_half(16'h3333);
    send_half(16'h4444);
    finish_burst();
    fetch("fetch_w5", 32'd20, 32'h22221111);
    fetch("fetch_w6", 32'd24, 32'h44443333);

    start_burst(DEPTH - 1, 2);
    send_half(16'hAAAA);
    send_half(16'h0001);
    send_half(16'hBBBB);
    send_half(16'h0002);
    finish_burst();
    fetch("fetch_w15", 32'd60, 32'h0001AAAA);
    fetch("fetch_wrap0", 32'd0, 32'h0002BBBB);

    fetch("pre_stall", 32'd20, 32'h22221111);
    stall_c0 = 1'b1;
    pc_read_c0 = 32'd24;
    step();
    check("stall_1", instr_reg_c1, 32'h22221111);
    pc_read_c0 = 32'd60;
    step();
    check("stall_2", instr_reg_c1, 32'h22221111);
    pc_read_c0 = 32'd0;
    step();
    check("stall_3", instr_reg_c1, 32'h22221111);
    stall_c0 = 1'b0;
    fetch("stall_release", 32'd60, 32'h0001AAAA);

    load_start_c0 = 1'b1;
    load_count_c0 = '0;
    step();
    load_start_c0 = 1'b0;
    check("zero_cnt_busy", load_busy, 0);
    check("zero_cnt_ready", load_ready_c0, 0);

    start_burst(3, 1);
    send_half(16'h5555);
    reset_n = 1'b0;
    step();
    check("abort_busy", load_busy, 0);
    check("abort_ready", load_ready_c0, 0);
    reset_n = 1'b1;
    step();
    start_burst(3, 1);
    send_half(16'h7777);
    send_half(16'h8888);
    finish_burst();
    fetch("after_abort_w3", 32'd12, 32'h88887777);
    fetch("kept_w5", 32'd20, 32'h22221111);

    start_burst(0, 1);
    check("ready_c0", load_ready_c0, 1);
    load_valid_c0 = 1'b1;
    load_half_c0 = 16'hCCCC;
    step();
    check("ready_c1", load_ready_c0, 1);
    load_half_c0 = 16'hDDDD;
    step();
    load_valid_c0 = 1'b0;
    check("write_ready_low", load_ready_c0, 0);
    pc_read_c0 = 32'd0;
    step();
    check("collide_old", instr_reg_c1, 32'h0002BBBB);
    check("collide_done", load_done, 1);
    step();
    check("collide_new", instr_reg_c1, 32'hDDDDCCCC);

`ifdef PMEM_GEN_RANGE_CHECK_EN
    pc_read_c0 = 32'h2;
    step();
    check("low_bits_instr", instr_reg_c1, NOP);
    check("low_bits_fault", fault_c1, 1);
    pc_read_c0 = 32'h40;
    step();
    check("high_bits_instr", instr_reg_c1, NOP);
    check("high_bits_fault", fault_c1, 1);
`else
    pc_read_c0 = 32'h2;
    step();
    check("low_bits_instr", instr_reg_c1, 32'hDDDDCCCC);
    check("low_bits_fault", fault_c1, 0);
    pc_read_c0 = 32'h54;
    step();
    check("high_bits_alias", instr_reg_c1, 32'h22221111);
    check("high_bits_fault", fault_c1, 0);
`endif
    fetch("inrange_after", 32'd24, 32'h44443333);
    check("inrange_fault", fault_c1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pmem_gen.md
PMEM_GEN -- requirements
Module: pmem_gen

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width; SHALL be a multiple of 16, legal values 32 or 64.
REQ-002 Parameter DEPTH_WORDS, default 32768: memory depth in words; SHALL be a power of two; ADDR_W = log2(DEPTH_WORDS).
REQ-003 Parameter NOP_INSTR, default 32'h00000013, zero-extended to DATA_W: value driven on reset and on range fault.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 pc_read_c0  in  32  byte fetch address; word index = pc_read_c0[ADDR_W+1:2] (DATA_W=32) or pc_read_c0[ADDR_W+2:3] (DATA_W=64).
REQ-007 stall_c0  in  1  holds the fetch output stage.
REQ-008 instr_reg_c1  out  DATA_W  registered instruction word.
REQ-009 instr_valid_c1  out  1  instr_reg_c1 holds a fetched word.
REQ-010 load_start_c0  in  1  starts a program-load burst.
REQ-011 load_base_c0  in  ADDR_W  first word index written by the burst.
REQ-012 load_count_c0  in  ADDR_W+1  number of words in the burst, 1..DEPTH_WORDS.
REQ-013 load_valid_c0 / load_half_c0[15:0] / load_ready_c0  in / in / out  halfword load stream, valid/ready handshake.
REQ-014 load_busy  out  1  burst in progress.
REQ-015 load_done  out  1  one-cycle pulse after the last word is written.
REQ-016 fault_c1  out  1  fetch address out of range (see Configuration).

Function
REQ-017 Fetch latency SHALL be 1 cycle: with stall_c0=0, instr_reg_c1 at edge N+1 = mem[index(pc_read_c0 at edge N)], and instr_valid_c1=1.
REQ-018 With stall_c0=1, instr_reg_c1, instr_valid_c1 and fault_c1 SHALL hold their values.
REQ-019 Loader FSM states: IDLE, COLLECT, WRITE; reset state IDLE.
REQ-020 IDLE -> COLLECT on load_start_c0=1: latch base and count, clear halfword index, load_busy=1 from the next cycle; load_start_c0 SHALL be ignored outside IDLE.
REQ-021 load_start_c0 with load_count_c0=0 SHALL be ignored; FSM stays in IDLE.
REQ-022 load_ready_c0 SHALL be 1 only in COLLECT; a transfer occurs when load_valid_c0 and load_ready_c0 are both 1.
REQ-023 Halfwords SHALL assemble lowest-first: the k-th transfer of a word fills bits [16k+15:16k]; after DATA_W/16 transfers the FSM SHALL enter WRITE.
REQ-024 WRITE SHALL last one cycle: write the word at the current address, increment the address modulo DEPTH_WORDS (wrap from DEPTH_WORDS-1 to 0), decrement the remaining count, then go to COLLECT, or to IDLE with load_done=1 when the count reaches 0.
REQ-025 Fetches SHALL continue during loading; a fetch and a write to the same index in the same cycle SHALL return the old word.

Reset
REQ-026 While reset_n=0 at a clock edge: instr_reg_c1=NOP_INSTR, instr_valid_c1=0, fault_c1=0, load_ready_c0=0, load_busy=0, load_done=0, FSM=IDLE, halfword index, address and count cleared.
REQ-027 A reset asserted mid-burst SHALL abort the burst; words already written SHALL remain; the partially assembled word SHALL be discarded; memory contents SHALL not be reset.

Configuration
REQ-028 Macro PMEM_GEN_RANGE_CHECK_EN defined: a fetch whose pc_read_c0 bits above the index field are nonzero, or whose bits below the index field are nonzero, SHALL produce instr_reg_c1=NOP_INSTR and fault_c1=1 at the same cycle the fetch would complete; otherwise fault_c1=0.
REQ-029 Macro not defined: upper and lower address bits SHALL be ignored (index aliasing); fault_c1 SHALL be tied to 0.

Verification
REQ-030 Reset, then pc_read_c0=0 with mem[0]=32'hDEADBEEF -> cycle 1: instr_reg_c1=32'hDEADBEEF, instr_valid_c1=1.
REQ-031 Load base=5, count=2, halfwords 1111,2222,3333,4444 -> mem[5]=32'h22221111, mem[6]=32'h44443333, load_done pulses once, load_busy then falls.
REQ-032 Load base=DEPTH_WORDS-1, count=2 -> words written to indices DEPTH_WORDS-1 and 0.
REQ-033 Stall held 3 cycles while pc_read_c0 changes -> instr_reg_c1 unchanged; first fetch after stall release returns the current address's word.
REQ-034 reset_n=0 after one halfword of a burst -> load_busy=0, load_ready_c0=0; a new burst writes correct words.
REQ-035 With the macro defined, pc_read_c0=32'h00000002 -> fault_c1=1 and instr_reg_c1=NOP_INSTR; without the macro -> mem[0] is returned and fault_c1=0.
